// File: rtl/attention_row_normalizer_if.sv
// Handshake and matrix bus between the attention array, the row normaliser and its consumer.
// The master side is upstream/consumer; the slave side is the normaliser.
interface attention_row_normalizer_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned ROW_W = $clog2(N);

    logic             in_valid;
    logic             in_ready;
    real              exp_matrix [0:N-1][0:N-1];
    real              num_matrix [0:N-1][0:N-1];
    logic             out_valid;
    logic             out_ready;
    real              out_row [0:N-1];
    logic [ROW_W-1:0] out_row_idx;
    real              out_row_sum;
    logic             out_row_zero;
    logic             out_last;
    logic             overrun;

    modport master (
        output in_valid, exp_matrix, num_matrix, out_ready,
        input  in_ready, out_valid, out_row, out_row_idx, out_row_sum, out_row_zero,
        input  out_last, overrun
    );

    modport slave (
        input  in_valid, exp_matrix, num_matrix, out_ready,
        output in_ready, out_valid, out_row, out_row_idx, out_row_sum, out_row_zero,
        output out_last, overrun
    );
endinterface

// File: rtl/attention_row_normalizer.sv
// Captures exp(QK^T) and exp(QK^T)V, sums each exponent row over N cycles and streams
// the numerator row divided by that sum, one row per valid/ready beat.
module attention_row_normalizer #(
    parameter int unsigned N   = 4,
    parameter real         EPS = 1.0e-12
) (
    input  logic                      clk,
    input  logic                      reset,
    attention_row_normalizer_if.slave bus
);
    localparam int unsigned      ROW_W = $clog2(N);
    localparam logic [ROW_W-1:0] LAST  = ROW_W'(N - 1);

    typedef enum logic [1:0] {StIdle, StSum, StDiv, StOut} state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, col_q;
    real              acc_q;
    real              exp_buf_q [0:N-1][0:N-1];
    real              num_buf_q [0:N-1][0:N-1];
    real              out_row_q [0:N-1];
    real              out_row_sum_q;
    logic [ROW_W-1:0] out_row_idx_q;
    logic             out_valid_q;
    logic             out_row_zero_q;
    logic             out_last_q;
    logic             overrun_q;

    logic capture;
    logic handshake;
    logic row_zero;

    assign handshake = out_valid_q && bus.out_ready;
    assign row_zero  = (acc_q < EPS) && (acc_q > -EPS);

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    capture = 1'b1;
                    state_d = StSum;
                end
            end
            StSum: begin
                if (col_q == LAST) begin
                    state_d = StDiv;
                end
            end
            StDiv: state_d = StOut;
            StOut: begin
                if (handshake) begin
                    state_d = (row_q == LAST) ? StIdle : StSum;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q          <= '0;
            col_q          <= '0;
            acc_q          <= 0.0;
            out_row_sum_q  <= 0.0;
            out_row_idx_q  <= '0;
            out_valid_q    <= 1'b0;
            out_row_zero_q <= 1'b0;
            out_last_q     <= 1'b0;
            overrun_q      <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                out_row_q[i] <= 0.0;
                for (int j = 0; j < int'(N); j++) begin
                    exp_buf_q[i][j] <= 0.0;
                    num_buf_q[i][j] <= 0.0;
                end
            end
        end else begin
            // A pulse outside IDLE is dropped; the buffers keep the matrix in flight.
            if (bus.in_valid && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (capture) begin
                        for (int i = 0; i < int'(N); i++) begin
                            for (int j = 0; j < int'(N); j++) begin
                                exp_buf_q[i][j] <= bus.exp_matrix[i][j];
                                num_buf_q[i][j] <= bus.num_matrix[i][j];
                            end
                        end
                        row_q <= '0;
                        col_q <= '0;
                        acc_q <= 0.0;
                    end
                end
                StSum: begin
                    acc_q <= acc_q + exp_buf_q[row_q][col_q];
                    col_q <= col_q + 1'b1;
                end
                StDiv: begin
                    out_row_sum_q  <= acc_q;
                    out_row_zero_q <= row_zero;
                    out_row_idx_q  <= row_q;
                    out_last_q     <= (row_q == LAST);
                    out_valid_q    <= 1'b1;
                    for (int j = 0; j < int'(N); j++) begin
                        out_row_q[j] <= row_zero ? 0.0 : num_buf_q[row_q][j] / acc_q;
                    end
                end
                StOut: begin
                    if (handshake) begin
                        out_valid_q <= 1'b0;
                        if (row_q != LAST) begin
                            row_q <= row_q + 1'b1;
                            col_q <= '0;
                            acc_q <= 0.0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready     = (state_q == StIdle);
    assign bus.out_valid    = out_valid_q;
    assign bus.out_row      = out_row_q;
    assign bus.out_row_idx  = out_row_idx_q;
    assign bus.out_row_sum  = out_row_sum_q;
    assign bus.out_row_zero = out_row_zero_q;
    assign bus.out_last     = out_last_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_attention_row_normalizer.sv
// Directed bench for attention_row_normalizer with N=4 and hand-computed row values.
module tb_attention_row_normalizer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   cyc;
    int   e0;

    attention_row_normalizer_if #(.N(4)) bus ();

    attention_row_normalizer #(.N(4), .EPS(1.0e-12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input real got, input real exp);
        real diff;
        n_checks++;
        diff = got - exp;
        if (diff < 1.0e-9 && diff > -1.0e-9) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %g expected %g", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input real e, input int zero_row);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                bus.exp_matrix[r][c] = (r == zero_row) ? 0.0 : e;
                bus.num_matrix[r][c] = 4.0 * (c + 1) * (r + 1);
            end
        end
    endtask

    task automatic capture();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40 && !bus.out_valid; i++) tick();
        check("valid_wait", bus.out_valid, 1.0);
    endtask

    // Row r of num is 4*(j+1)*(r+1) and every exp entry is e, so the row sum is 4e.
    task automatic expect_row(input int r, input bit zero, input real e);
        real exp_v;
        wait_valid();
        check($sformatf("r%0d_idx", r), bus.out_row_idx, r);
        check($sformatf("r%0d_zero", r), bus.out_row_zero, zero);
        check($sformatf("r%0d_last", r), bus.out_last, (r == 3) ? 1.0 : 0.0);
        check($sformatf("r%0d_sum", r), bus.out_row_sum, zero ? 0.0 : 4.0 * e);
        check($sformatf("r%0d_in_ready", r), bus.in_ready, 0.0);
        for (int j = 0; j < 4; j++) begin
            exp_v = zero ? 0.0 : real'((j + 1) * (r + 1)) / e;
            check($sformatf("r%0d_col%0d", r, j), bus.out_row[j], exp_v);
        end
        if (bus.out_ready) tick();
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        cyc          = 0;
        e0           = 0;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        load(1.0, -1);
        #3;
        check("rst_out_valid", bus.out_valid, 0.0);
        check("rst_in_ready", bus.in_ready, 1.0);
        check("rst_overrun", bus.overrun, 0.0);
        check("rst_sum", bus.out_row_sum, 0.0);
        check("rst_idx", bus.out_row_idx, 0.0);
        check("rst_last", bus.out_last, 0.0);
        check("rst_zero", bus.out_row_zero, 0.0);
        check("rst_row0", bus.out_row[0], 0.0);
        tick();
        reset = 1'b1;
        tick();

        // Nominal run with latency and completion timing
        capture();
        for (int i = 0; i < 4; i++) tick();
        check("lat_e4_valid", bus.out_valid, 0.0);
        tick();
        check("lat_e5_valid", bus.out_valid, 1.0);
        for (int r = 0; r < 4; r++) expect_row(r, 1'b0, 1.0);
        check("done_cycles", cyc - e0, 24.0);
        check("done_in_ready", bus.in_ready, 1.0);

        // Backpressure on row 1
        capture();
        expect_row(0, 1'b0, 1.0);
        bus.out_ready = 1'b0;
        wait_valid();
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", bus.out_valid, 1.0);
            check("bp_idx", bus.out_row_idx, 1.0);
            check("bp_sum", bus.out_row_sum, 4.0);
            for (int j = 0; j < 4; j++) check("bp_col", bus.out_row[j], 2.0 * (j + 1));
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("bp_hs_valid", bus.out_valid, 0.0);
        for (int i = 0; i < 4; i++) tick();
        check("bp_r2_e4", bus.out_valid, 0.0);
        tick();
        check("bp_r2_e5", bus.out_valid, 1.0);
        expect_row(2, 1'b0, 1.0);
        expect_row(3, 1'b0, 1.0);

        // Zero row 2
        load(1.0, 2);
        capture();
        for (int r = 0; r < 4; r++) expect_row(r, (r == 2), 1.0);

        // Overrun during SUM of row 1
        load(1.0, -1);
        check("ov_before", bus.overrun, 0.0);
        capture();
        expect_row(0, 1'b0, 1.0);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                bus.exp_matrix[r][c] = 3.0;
                bus.num_matrix[r][c] = 100.0;
            end
        end
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("ov_set", bus.overrun, 1.0);
        for (int r = 1; r < 4; r++) expect_row(r, 1'b0, 1.0);
        tick();
        check("ov_idle_ready", bus.in_ready, 1.0);
        check("ov_sticky", bus.overrun, 1.0);

        // Reset during OUT of row 2
        load(1.0, -1);
        capture();
        expect_row(0, 1'b0, 1.0);
        expect_row(1, 1'b0, 1.0);
        bus.out_ready = 1'b0;
        wait_valid();
        check("rm_idx", bus.out_row_idx, 2.0);
        reset = 1'b0;
        #1;
        check("rm_out_valid", bus.out_valid, 0.0);
        check("rm_in_ready", bus.in_ready, 1.0);
        check("rm_overrun", bus.overrun, 0.0);
        #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        capture();
        for (int r = 0; r < 4; r++) expect_row(r, 1'b0, 1.0);
        check("rm_after_overrun", bus.overrun, 0.0);

        // Back-to-back: pulse on the last handshake is an overrun, the next one captures
        capture();
        for (int r = 0; r < 3; r++) expect_row(r, 1'b0, 1.0);
        wait_valid();
        check("bb_r3_idx", bus.out_row_idx, 3.0);
        bus.in_valid = 1'b1;
        tick();
        check("bb_overrun", bus.overrun, 1.0);
        check("bb_ready", bus.in_ready, 1.0);
        load(2.0, -1);
        tick();
        bus.in_valid = 1'b0;
        check("bb_captured", bus.in_ready, 0.0);
        for (int r = 0; r < 4; r++) expect_row(r, 1'b0, 2.0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
